// File: rtl/rotation_reg_pkg.sv
// Shared register-map constants for the swerve rotation register bank.
package rotation_reg_pkg;

    typedef enum logic [1:0] {
        OFF_CTRL    = 2'd0,
        OFF_TARG_LO = 2'd1,
        OFF_STATUS  = 2'd2,
        OFF_CUR_LO  = 2'd3
    } reg_off_e;

    localparam int CH_STRIDE = 4;

    localparam logic [5:0] WD_CTRL_ADDR = 6'h3E;
    localparam logic [5:0] BCAST_ADDR   = 6'h3F;

    localparam int ST_FAULT_BIT = 7;
    localparam int ST_SFAIL_BIT = 6;
    localparam int ST_DONE_BIT  = 5;

    localparam int WD_EN_BIT   = 0;
    localparam int WD_TRIP_BIT = 1;

endpackage

// File: rtl/rotation_reg_channel.sv
// One rotation channel: control bits, staged target commit, sticky faults
// and the current-angle high-byte snapshot.
module rotation_reg_channel
    import rotation_reg_pkg::*;
#(
    parameter int ANGLE_W = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_we,
    input  logic               targ_we,
    input  logic               status_we,
    input  logic               snap_en,
    input  logic               wd_trip,
    input  logic [7:0]         wr_data,
    input  logic [1:0]         rd_sel,
    input  logic               fault,
    input  logic               startup_fail,
    input  logic               angle_done,
    input  logic [ANGLE_W-1:0] current_angle,
    output logic               brake,
    output logic               enable,
    output logic               direction,
    output logic [ANGLE_W-1:0] target_angle,
    output logic               update_angle,
    output logic [7:0]         rd_byte
);

    localparam int H = ANGLE_W - 8;

    logic [H-1:0] stage_hi;
    logic [H-1:0] snap_hi;
    logic         fault_s;
    logic         sfail_s;

    // Sticky bits: a high input always wins over a same-cycle W1C clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            brake        <= 1'b0;
            enable       <= 1'b0;
            direction    <= 1'b0;
            stage_hi     <= '0;
            target_angle <= '0;
            update_angle <= 1'b0;
            fault_s      <= 1'b0;
            sfail_s      <= 1'b0;
            snap_hi      <= '0;
        end else begin
            if (ctrl_we) begin
                brake     <= wr_data[7];
                enable    <= wr_data[6];
                direction <= wr_data[5];
                stage_hi  <= wr_data[H-1:0];
            end
            if (wd_trip) begin
                enable <= 1'b0;
            end
            update_angle <= targ_we;
            if (targ_we) begin
                target_angle <= {stage_hi, wr_data};
            end
            fault_s <= fault | (fault_s & ~(status_we & wr_data[ST_FAULT_BIT]));
            sfail_s <= startup_fail | (sfail_s & ~(status_we & wr_data[ST_SFAIL_BIT]));
            if (snap_en) begin
                snap_hi <= current_angle[ANGLE_W-1:8];
            end
        end
    end

    always_comb begin
        rd_byte = '0;
        case (reg_off_e'(rd_sel))
            OFF_CTRL:    rd_byte = {brake, enable, direction, 1'b0, 4'(stage_hi)};
            OFF_TARG_LO: rd_byte = target_angle[7:0];
            OFF_STATUS: begin
                rd_byte[ST_FAULT_BIT] = fault_s;
                rd_byte[ST_SFAIL_BIT] = sfail_s;
                rd_byte[ST_DONE_BIT]  = angle_done;
                rd_byte[3:0]          = 4'(snap_hi);
            end
            OFF_CUR_LO:  rd_byte = current_angle[7:0];
            default:     rd_byte = '0;
        endcase
    end

endmodule

// File: rtl/rotation_reg_bank.sv
// Host-facing register bank for the rotation channels: address decode,
// registered read mux and the host-activity watchdog.
module rotation_reg_bank
    import rotation_reg_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ANGLE_W   = 12,
    parameter int WD_CYCLES = 50_000_000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [5:0]                address,
    input  logic                      write_en,
    input  logic [7:0]                wr_data,
    input  logic                      read_en,
    output logic [7:0]                rd_data,
    output logic                      rd_valid,
    input  logic [NUM_CH-1:0]         fault,
    input  logic [NUM_CH-1:0]         startup_fail,
    input  logic [NUM_CH-1:0]         angle_done,
    input  logic [NUM_CH*ANGLE_W-1:0] current_angle,
    output logic [NUM_CH-1:0]         brake,
    output logic [NUM_CH-1:0]         enable,
    output logic [NUM_CH-1:0]         direction,
    output logic [NUM_CH*ANGLE_W-1:0] target_angle,
    output logic [NUM_CH-1:0]         update_angle,
    output logic                      wd_tripped
);

    localparam int WD_W = $clog2(WD_CYCLES);

    reg_off_e          offset;
    logic [NUM_CH-1:0] ch_sel;
    logic [7:0]        ch_rd [NUM_CH];
    logic [7:0]        rd_next;
    logic              wd_en;
    logic              wd_trip;
    logic              wd_ctrl_we;
    logic              bcast_we;
    logic [WD_W-1:0]   wd_count;

    assign offset     = reg_off_e'(address[1:0]);
    assign wd_ctrl_we = write_en && (address == WD_CTRL_ADDR);
    assign bcast_we   = write_en && (address == BCAST_ADDR);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [5:0] BASE = 6'(i * CH_STRIDE);

        assign ch_sel[i] = (address - BASE) < 6'(CH_STRIDE);

        rotation_reg_channel #(
            .ANGLE_W(ANGLE_W)
        ) u_channel (
            .clock        (clock),
            .reset        (reset),
            .ctrl_we      (bcast_we || (write_en && ch_sel[i] && offset == OFF_CTRL)),
            .targ_we      (write_en && ch_sel[i] && offset == OFF_TARG_LO),
            .status_we    (write_en && ch_sel[i] && offset == OFF_STATUS),
            .snap_en      (read_en && ch_sel[i] && offset == OFF_CUR_LO),
            .wd_trip      (wd_trip),
            .wr_data      (wr_data),
            .rd_sel       (address[1:0]),
            .fault        (fault[i]),
            .startup_fail (startup_fail[i]),
            .angle_done   (angle_done[i]),
            .current_angle(current_angle[i*ANGLE_W +: ANGLE_W]),
            .brake        (brake[i]),
            .enable       (enable[i]),
            .direction    (direction[i]),
            .target_angle (target_angle[i*ANGLE_W +: ANGLE_W]),
            .update_angle (update_angle[i]),
            .rd_byte      (ch_rd[i])
        );
    end

    // Reads sample the pre-write register state; BCAST and unmapped read 0.
    always_comb begin
        rd_next = '0;
        if (address == WD_CTRL_ADDR) begin
            rd_next[WD_EN_BIT]   = wd_en;
            rd_next[WD_TRIP_BIT] = wd_tripped;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel[i]) begin
                rd_next = ch_rd[i];
            end
        end
    end

    // Trip fires on the edge the counter would land on WD_CYCLES-1.
    assign wd_trip = wd_en && !write_en && (wd_count == WD_W'(WD_CYCLES - 2));

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_en      <= 1'b0;
            wd_tripped <= 1'b0;
            wd_count   <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            if (write_en || !wd_en) begin
                wd_count <= '0;
            end else if (wd_count != WD_W'(WD_CYCLES - 1)) begin
                wd_count <= wd_count + WD_W'(1);
            end
            if (wd_trip) begin
                wd_tripped <= 1'b1;
            end else if (wd_ctrl_we && wr_data[WD_TRIP_BIT]) begin
                wd_tripped <= 1'b0;
            end
            if (wd_ctrl_we) begin
                wd_en <= wr_data[WD_EN_BIT];
            end
            rd_valid <= read_en;
            if (read_en) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_rotation_reg_bank.sv
// Randomised and directed bench for rotation_reg_bank against a register-map model.
module tb_rotation_reg_bank;

    localparam int NUM_CH    = 4;
    localparam int ANGLE_W   = 12;
    localparam int WD_CYCLES = 16;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [5:0]                address;
    logic                      write_en;
    logic [7:0]                wr_data;
    logic                      read_en;
    logic [7:0]                rd_data;
    logic                      rd_valid;
    logic [NUM_CH-1:0]         fault;
    logic [NUM_CH-1:0]         startup_fail;
    logic [NUM_CH-1:0]         angle_done;
    logic [NUM_CH*ANGLE_W-1:0] current_angle;
    logic [NUM_CH-1:0]         brake;
    logic [NUM_CH-1:0]         enable;
    logic [NUM_CH-1:0]         direction;
    logic [NUM_CH*ANGLE_W-1:0] target_angle;
    logic [NUM_CH-1:0]         update_angle;
    logic                      wd_tripped;

    int checks   = 0;
    int failures = 0;

    logic [7:0]         m_ctrl   [NUM_CH];
    logic [ANGLE_W-1:0] m_target [NUM_CH];
    logic               m_fault  [NUM_CH];
    logic               m_sfail  [NUM_CH];
    logic [3:0]         m_snap   [NUM_CH];
    logic               m_wd_en;
    logic               m_trip;

    rotation_reg_bank #(
        .NUM_CH   (NUM_CH),
        .ANGLE_W  (ANGLE_W),
        .WD_CYCLES(WD_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .write_en     (write_en),
        .wr_data      (wr_data),
        .read_en      (read_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fault        (fault),
        .startup_fail (startup_fail),
        .angle_done   (angle_done),
        .current_angle(current_angle),
        .brake        (brake),
        .enable       (enable),
        .direction    (direction),
        .target_angle (target_angle),
        .update_angle (update_angle),
        .wd_tripped   (wd_tripped)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_ctrl[i]   = 8'h00;
            m_target[i] = '0;
            m_fault[i]  = 1'b0;
            m_sfail[i]  = 1'b0;
            m_snap[i]   = 4'h0;
        end
        m_wd_en = 1'b0;
        m_trip  = 1'b0;
    endtask

    task automatic model_write(input logic [5:0] a, input logic [7:0] d);
        int ch  = int'(a) / 4;
        int off = int'(a) % 4;
        if (a == 6'h3F) begin
            for (int i = 0; i < NUM_CH; i++) m_ctrl[i] = d & 8'hEF;
        end else if (a == 6'h3E) begin
            m_wd_en = d[0];
            if (d[1]) m_trip = 1'b0;
        end else if (ch < NUM_CH) begin
            case (off)
                0: m_ctrl[ch] = d & 8'hEF;
                1: m_target[ch] = {m_ctrl[ch][3:0], d};
                2: begin
                    if (d[7]) m_fault[ch] = 1'b0;
                    if (d[6]) m_sfail[ch] = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [7:0] exp_read(input logic [5:0] a);
        int ch  = int'(a) / 4;
        int off = int'(a) % 4;
        logic [7:0] v;
        v = 8'h00;
        if (a == 6'h3E) begin
            v = {6'b0, m_trip, m_wd_en};
        end else if (ch < NUM_CH) begin
            case (off)
                0: v = m_ctrl[ch];
                1: v = m_target[ch][7:0];
                2: v = {m_fault[ch], m_sfail[ch], angle_done[ch], 1'b0, m_snap[ch]};
                default: v = current_angle[ch*ANGLE_W +: 8];
            endcase
        end
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_ctrl_bit(input int b);
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_ctrl[i][b];
        return v;
    endfunction

    function automatic logic [NUM_CH*ANGLE_W-1:0] exp_targets();
        logic [NUM_CH*ANGLE_W-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i*ANGLE_W +: ANGLE_W] = m_target[i];
        return v;
    endfunction

    task automatic step();
        logic [NUM_CH-1:0] f;
        logic [NUM_CH-1:0] s;
        f = fault;
        s = startup_fail;
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (f[i]) m_fault[i] = 1'b1;
            if (s[i]) m_sfail[i] = 1'b1;
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d);
        address  = a;
        wr_data  = d;
        write_en = 1'b1;
        model_write(a, d);
        step();
        write_en = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [7:0] got,
                           output logic vld, output logic [7:0] expd);
        int ch = int'(a) / 4;
        expd    = exp_read(a);
        address = a;
        read_en = 1'b1;
        if (a[1:0] == 2'd3 && ch < NUM_CH) m_snap[ch] = current_angle[ch*ANGLE_W + 8 +: 4];
        step();
        got     = rd_data;
        vld     = rd_valid;
        read_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] got, expd;
        logic       vld;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_reset();
        checks++;
        if ({brake, enable, direction, update_angle} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%h exp=0", {brake, enable, direction, update_angle});
        end
        checks++;
        if (target_angle !== '0 || wd_tripped !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_target got=%h/%b exp=0/0", target_angle, wd_tripped);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_rd got=%b/%h exp=0/00", rd_valid, rd_data);
        end
        do_read(6'h3E, got, vld, expd);
        checks++;
        if (got !== 8'h00 || vld !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_wdctrl got=%h/%b exp=00/1", got, vld);
        end
    endtask

    task automatic test_ctrl_then_target();
        do_write(6'h04, 8'h4A);
        checks++;
        if (enable[1] !== 1'b1 || direction[1] !== 1'b0 || brake[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ctrl_bits got=%b%b%b exp=010", brake[1], enable[1], direction[1]);
        end
        checks++;
        if (target_angle[ANGLE_W +: ANGLE_W] !== 12'h000 || update_angle !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL ctrl_no_commit got=%h/%b exp=000/0000",
                     target_angle[ANGLE_W +: ANGLE_W], update_angle);
        end
        do_write(6'h05, 8'h34);
        checks++;
        if (target_angle[ANGLE_W +: ANGLE_W] !== 12'hA34) begin
            failures++;
            $display("[TB] FAIL targ_commit got=%h exp=a34", target_angle[ANGLE_W +: ANGLE_W]);
        end
        checks++;
        if (update_angle !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL targ_pulse got=%b exp=0010", update_angle);
        end
        step();
        checks++;
        if (update_angle !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL targ_pulse_end got=%b exp=0000", update_angle);
        end
    endtask

    task automatic test_random_traffic();
        logic [7:0]        got, expd, d;
        logic [5:0]        a;
        logic              vld;
        logic [NUM_CH-1:0] exp_upd;
        for (int n = 0; n < 40; n++) begin
            fault        = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom()) : '0;
            startup_fail = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom()) : '0;
            angle_done   = NUM_CH'($urandom());
            for (int i = 0; i < NUM_CH; i++) current_angle[i*ANGLE_W +: ANGLE_W] = ANGLE_W'($urandom());
            a = 6'($urandom_range(0, 63));
            if (a == 6'h3E) a = 6'h3F;
            d = 8'($urandom());
            exp_upd = '0;
            if (int'(a) / 4 < NUM_CH && a[1:0] == 2'd1) exp_upd[int'(a) / 4] = 1'b1;
            do_write(a, d);
            checks++;
            if ({brake, enable, direction} !== {exp_ctrl_bit(7), exp_ctrl_bit(6), exp_ctrl_bit(5)}) begin
                failures++;
                $display("[TB] FAIL rand_ctrl n=%0d addr=%h got=%h exp=%h", n, a, {brake, enable, direction},
                         {exp_ctrl_bit(7), exp_ctrl_bit(6), exp_ctrl_bit(5)});
            end
            checks++;
            if (target_angle !== exp_targets() || update_angle !== exp_upd || rd_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rand_commit n=%0d got=%h/%b/%b exp=%h/%b/0", n, target_angle,
                         update_angle, rd_valid, exp_targets(), exp_upd);
            end
            fault        = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom()) : '0;
            startup_fail = '0;
            do_read(6'($urandom_range(0, 63)), got, vld, expd);
            checks++;
            if (got !== expd || vld !== 1'b1 || update_angle !== '0) begin
                failures++;
                $display("[TB] FAIL rand_read n=%0d addr=%h got=%h/%b exp=%h/1 upd=%b", n, address,
                         got, vld, expd, update_angle);
            end
        end
        fault        = '0;
        startup_fail = '0;
    endtask

    task automatic test_back_to_back();
        address  = 6'h01;
        wr_data  = 8'h11;
        write_en = 1'b1;
        model_write(6'h01, 8'h11);
        step();
        checks++;
        if (update_angle !== 4'b0001 || target_angle !== exp_targets()) begin
            failures++;
            $display("[TB] FAIL b2b_first got=%b/%h exp=0001/%h", update_angle, target_angle, exp_targets());
        end
        wr_data = 8'h22;
        model_write(6'h01, 8'h22);
        step();
        write_en = 1'b0;
        checks++;
        if (update_angle !== 4'b0001 || target_angle[7:0] !== 8'h22) begin
            failures++;
            $display("[TB] FAIL b2b_second got=%b/%h exp=0001/22", update_angle, target_angle[7:0]);
        end
        step();
        checks++;
        if (update_angle !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL b2b_end got=%b exp=0000", update_angle);
        end
    endtask

    task automatic test_bcast();
        logic [7:0] got, expd;
        logic       vld;
        do_write(6'h3F, 8'hC0);
        checks++;
        if (brake !== 4'hF || enable !== 4'hF || direction !== 4'h0) begin
            failures++;
            $display("[TB] FAIL bcast_ctrl got=%h%h%h exp=ff0", brake, enable, direction);
        end
        do_read(6'h00, got, vld, expd);
        checks++;
        if (got !== 8'hC0 || vld !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bcast_readback got=%h/%b exp=c0/1", got, vld);
        end
        step();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'hC0) begin
            failures++;
            $display("[TB] FAIL rd_hold got=%b/%h exp=0/c0", rd_valid, rd_data);
        end
        do_read(6'h3F, got, vld, expd);
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("[TB] FAIL bcast_read got=%h exp=00", got);
        end
    endtask

    task automatic test_sticky();
        logic [7:0] got, expd;
        logic       vld;
        fault[2] = 1'b1;
        step();
        fault[2] = 1'b0;
        do_read(6'h0A, got, vld, expd);
        checks++;
        if (got[7] !== 1'b1 || got !== expd) begin
            failures++;
            $display("[TB] FAIL sticky_set got=%h exp=%h", got, expd);
        end
        do_write(6'h0A, 8'h80);
        do_read(6'h0A, got, vld, expd);
        checks++;
        if (got[7] !== 1'b0 || got !== expd) begin
            failures++;
            $display("[TB] FAIL sticky_clear got=%h exp=%h", got, expd);
        end
        fault[2] = 1'b1;
        do_write(6'h0A, 8'h80);
        fault[2] = 1'b0;
        do_read(6'h0A, got, vld, expd);
        checks++;
        if (got[7] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sticky_set_wins got=%h exp=1xxxxxxx", got);
        end
        startup_fail[1] = 1'b1;
        step();
        startup_fail[1] = 1'b0;
        do_write(6'h06, 8'h40);
        do_read(6'h06, got, vld, expd);
        checks++;
        if (got[6] !== 1'b0 || got !== expd) begin
            failures++;
            $display("[TB] FAIL sfail_clear got=%h exp=%h", got, expd);
        end
        do_read(6'h20, got, vld, expd);
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("[TB] FAIL unmapped_read got=%h exp=00", got);
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] got, expd;
        logic       vld;
        angle_done = '0;
        current_angle[0 +: ANGLE_W] = 12'h5F3;
        do_read(6'h03, got, vld, expd);
        checks++;
        if (got !== 8'hF3) begin
            failures++;
            $display("[TB] FAIL cur_lo got=%h exp=f3", got);
        end
        current_angle[0 +: ANGLE_W] = 12'h7AA;
        do_read(6'h02, got, vld, expd);
        checks++;
        if (got[3:0] !== 4'h5 || got !== expd) begin
            failures++;
            $display("[TB] FAIL snap_hi got=%h exp=%h", got, expd);
        end
    endtask

    task automatic test_same_cycle_rw();
        logic [7:0] old_val;
        old_val  = m_ctrl[3];
        address  = 6'h0C;
        wr_data  = ~old_val & 8'hEF;
        write_en = 1'b1;
        read_en  = 1'b1;
        model_write(6'h0C, ~old_val & 8'hEF);
        step();
        write_en = 1'b0;
        read_en  = 1'b0;
        checks++;
        if (rd_data !== old_val || enable[3] !== m_ctrl[3][6]) begin
            failures++;
            $display("[TB] FAIL rw_same_cycle got=%h/%b exp=%h/%b", rd_data, enable[3], old_val, m_ctrl[3][6]);
        end
    endtask

    task automatic test_watchdog();
        logic [7:0] got, expd;
        logic       vld;
        do_write(6'h3E, 8'h01);
        do_write(6'h3F, 8'h40);
        for (int k = 0; k < WD_CYCLES - 2; k++) step();
        checks++;
        if (wd_tripped !== 1'b0 || enable !== 4'hF) begin
            failures++;
            $display("[TB] FAIL wd_early got=%b/%h exp=0/f", wd_tripped, enable);
        end
        step();
        m_trip = 1'b1;
        for (int i = 0; i < NUM_CH; i++) m_ctrl[i][6] = 1'b0;
        checks++;
        if (wd_tripped !== 1'b1 || enable !== 4'h0) begin
            failures++;
            $display("[TB] FAIL wd_trip got=%b/%h exp=1/0", wd_tripped, enable);
        end
        do_read(6'h3E, got, vld, expd);
        checks++;
        if (got !== 8'h03 || got !== expd) begin
            failures++;
            $display("[TB] FAIL wd_read got=%h exp=03", got);
        end
        do_write(6'h3E, 8'h02);
        do_write(6'h04, 8'h40);
        checks++;
        if (wd_tripped !== 1'b0 || enable[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wd_clear got=%b/%b exp=0/1", wd_tripped, enable[1]);
        end
        do_write(6'h3E, 8'h01);
        for (int k = 0; k < WD_CYCLES - 2; k++) step();
        do_write(6'h00, 8'h40);
        checks++;
        if (wd_tripped !== 1'b0 || enable[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wd_write_saves got=%b/%b exp=0/1", wd_tripped, enable[0]);
        end
        for (int k = 0; k < WD_CYCLES - 2; k++) step();
        checks++;
        if (wd_tripped !== 1'b0 || enable !== exp_ctrl_bit(6)) begin
            failures++;
            $display("[TB] FAIL wd_restart got=%b/%h exp=0/%h", wd_tripped, enable, exp_ctrl_bit(6));
        end
        do_write(6'h3E, 8'h00);
    endtask

    task automatic test_reset_mid();
        logic [7:0] got, expd;
        logic       vld;
        do_write(6'h00, 8'h4F);
        address  = 6'h01;
        wr_data  = 8'h55;
        write_en = 1'b1;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        write_en = 1'b0;
        model_reset();
        checks++;
        if ({brake, enable, direction, update_angle} !== '0 || target_angle !== '0 || wd_tripped !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid got=%h/%h exp=0/0", {brake, enable, direction, update_angle}, target_angle);
        end
        step();
        checks++;
        if (update_angle !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_pulse got=%b exp=0000", update_angle);
        end
        do_read(6'h00, got, vld, expd);
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_stage got=%h exp=00", got);
        end
    endtask

    initial begin
        reset         = 1'b1;
        address       = '0;
        write_en      = 1'b0;
        wr_data       = '0;
        read_en       = 1'b0;
        fault         = '0;
        startup_fail  = '0;
        angle_done    = '0;
        current_angle = '0;
        model_reset();
        test_reset();
        test_ctrl_then_target();
        test_random_traffic();
        test_back_to_back();
        test_bcast();
        test_sticky();
        test_snapshot();
        test_same_cycle_rw();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
